// File: rtl/gigatron_video_out_if.sv
// rtl/gigatron_video_out_if.sv - video output bundle from the Gigatron video stage to the platform video path
interface gigatron_video_out_if #(
  parameter int unsigned OUT_W = 8
);
  logic [OUT_W-1:0] VGA_R;
  logic [OUT_W-1:0] VGA_G;
  logic [OUT_W-1:0] VGA_B;
  logic             VGA_HS;
  logic             VGA_VS;
  logic             HBlank;
  logic             VBlank;
  logic             ce_pix;
  logic             frame_start;
  logic             h_locked;

  modport master (
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
    output HBlank, VBlank, ce_pix, frame_start, h_locked
  );

  modport slave (
    input VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
    input HBlank, VBlank, ce_pix, frame_start, h_locked
  );
endinterface

// File: rtl/gigatron_video_out.sv
// rtl/gigatron_video_out.sv - registered Gigatron video output stage: colour widening, sync regeneration, blanking, h-lock
// Optional scanline darkening is built when GIGATRON_SCANLINE_EN is defined.
module gigatron_video_out #(
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned H_BP       = 12,
  parameter int unsigned H_ACT      = 160,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned V_ACT      = 480,
  parameter bit          SYNC_HIGH  = 1'b1,
  parameter bit          BLANK_ZERO = 1'b1
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [7:0]           out_port,
  input  logic                 scanline_on,
  gigatron_video_out_if.master vid
);
  localparam logic [8:0] H_MAX = 9'd511;
  localparam logic [9:0] V_MAX = 10'd1023;

  logic             hs_prev, vs_prev;
  logic [8:0]       hcnt, hcnt_nxt;
  logic [8:0]       hper, hper_inc, last_per;
  logic [9:0]       vcnt, vcnt_nxt;
  logic [1:0]       edge_cnt;
  logic             h_rise, v_rise;
  logic             hblank_nxt, vblank_nxt, blank, dim;
  logic [OUT_W-1:0] r_out, g_out, b_out;

  function automatic logic [OUT_W-1:0] expand(input logic [1:0] c);
    logic [OUT_W-1:0] e;
    e = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      e[int'(OUT_W) - 1 - i] = (i % 2 == 0) ? c[1] : c[0];
    end
    return e;
  endfunction

`ifdef GIGATRON_SCANLINE_EN
  assign dim = scanline_on && vcnt_nxt[0];
`else
  logic unused_scanline;
  assign unused_scanline = scanline_on;
  assign dim = 1'b0;
`endif

  // Blanking and colour are derived from the post-update counters so every
  // output reflects the same sample one clk after its ce.
  always_comb begin
    h_rise   = !hs_prev && out_port[6];
    v_rise   = !vs_prev && out_port[7];
    hcnt_nxt = h_rise ? 9'd0 : ((hcnt == H_MAX) ? H_MAX : hcnt + 9'd1);
    hper_inc = (hper == H_MAX) ? H_MAX : hper + 9'd1;
    if (v_rise) begin
      vcnt_nxt = '0;
    end else if (h_rise && vcnt != V_MAX) begin
      vcnt_nxt = vcnt + 10'd1;
    end else begin
      vcnt_nxt = vcnt;
    end
    hblank_nxt = !((32'(hcnt_nxt) >= H_BP) && (32'(hcnt_nxt) < H_BP + H_ACT));
    vblank_nxt = !((32'(vcnt_nxt) >= V_BP) && (32'(vcnt_nxt) < V_BP + V_ACT));
    blank      = BLANK_ZERO && (hblank_nxt || vblank_nxt);
  end

  always_comb begin
    r_out = expand(out_port[1:0]);
    g_out = expand(out_port[3:2]);
    b_out = expand(out_port[5:4]);
    if (dim) begin
      r_out = r_out >> 1;
      g_out = g_out >> 1;
      b_out = b_out >> 1;
    end
    if (blank) begin
      r_out = '0;
      g_out = '0;
      b_out = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev         <= 1'b1;
      vs_prev         <= 1'b1;
      hcnt            <= H_MAX;
      vcnt            <= V_MAX;
      hper            <= '0;
      last_per        <= '0;
      edge_cnt        <= '0;
      vid.VGA_R       <= '0;
      vid.VGA_G       <= '0;
      vid.VGA_B       <= '0;
      vid.VGA_HS      <= !SYNC_HIGH;
      vid.VGA_VS      <= !SYNC_HIGH;
      vid.HBlank      <= 1'b1;
      vid.VBlank      <= 1'b1;
      vid.ce_pix      <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.h_locked    <= 1'b0;
    end else begin
      vid.ce_pix <= ce;
      if (ce) begin
        hs_prev         <= out_port[6];
        vs_prev         <= out_port[7];
        hcnt            <= hcnt_nxt;
        vcnt            <= vcnt_nxt;
        vid.VGA_R       <= r_out;
        vid.VGA_G       <= g_out;
        vid.VGA_B       <= b_out;
        vid.VGA_HS      <= SYNC_HIGH ? !out_port[6] : out_port[6];
        vid.VGA_VS      <= SYNC_HIGH ? !out_port[7] : out_port[7];
        vid.HBlank      <= hblank_nxt;
        vid.VBlank      <= vblank_nxt;
        vid.frame_start <= (32'(vcnt_nxt) == V_BP) && (32'(vcnt) != V_BP);
        // The first edge after reset only opens a period; lock needs two
        // complete periods behind it, hence the edge_cnt gate.
        if (h_rise) begin
          hper         <= '0;
          last_per     <= hper;
          vid.h_locked <= (edge_cnt == 2'd2) && (hper == last_per) && (hper != H_MAX);
          if (edge_cnt != 2'd2) begin
            edge_cnt <= edge_cnt + 2'd1;
          end
        end else begin
          hper <= hper_inc;
          if (hper_inc == H_MAX) begin
            vid.h_locked <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_gigatron_video_out.sv
// tb/tb_gigatron_video_out.sv - self-checking bench for gigatron_video_out
module tb_gigatron_video_out;
  localparam int OUT_W = 8;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b1;
  logic       ce = 1'b0;
  logic       scanline_on = 1'b0;
  logic [7:0] out_port = 8'hFF;

  int n_checks = 0;
  int n_fail   = 0;

  gigatron_video_out_if #(.OUT_W(OUT_W)) vid ();

  gigatron_video_out #(.OUT_W(OUT_W)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ce          (ce),
    .out_port    (out_port),
    .scanline_on (scanline_on),
    .vid         (vid)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: positions as plain integers, measured periods in a queue.
  bit         m_hs_prev, m_vs_prev, seen_rise;
  int         h_pos, v_line, per_pos;
  int         periods[$];
  logic [7:0] e_r, e_g, e_b;
  bit         e_hs, e_vs, e_hb, e_vb, e_cepix, e_fs, e_lock;

  typedef struct {
    bit         c;
    logic [7:0] p;
    logic [7:0] r, g, b;
    bit         hs, vs, cp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] widen(input logic [1:0] c);
    return 8'(c) * 8'h55;
  endfunction

  task automatic model_reset();
    m_hs_prev = 1; m_vs_prev = 1; seen_rise = 0;
    h_pos = 511; v_line = 1023; per_pos = 0;
    periods.delete();
    e_r = 0; e_g = 0; e_b = 0; e_hs = 0; e_vs = 0;
    e_hb = 1; e_vb = 1; e_cepix = 0; e_fs = 0; e_lock = 0;
  endtask

  task automatic model_update(input bit c, input logic [7:0] p);
    bit hr, vr;
    int old_line;
    e_cepix = c;
    if (!c) return;
    hr = !m_hs_prev && p[6];
    vr = !m_vs_prev && p[7];
    m_hs_prev = p[6];
    m_vs_prev = p[7];
    old_line = v_line;
    if (hr) h_pos = 0; else if (h_pos < 511) h_pos++;
    if (vr) v_line = 0; else if (hr && v_line < 1023) v_line++;
    if (hr) begin
      if (seen_rise) periods.push_back(per_pos);
      if (periods.size() > 2) void'(periods.pop_front());
      seen_rise = 1;
      per_pos = 0;
      e_lock = (periods.size() == 2) && (periods[0] == periods[1]) && (periods[1] < 511);
    end else begin
      if (per_pos < 511) per_pos++;
      if (per_pos >= 511) e_lock = 0;
    end
    e_hb = !(h_pos >= 12 && h_pos < 172);
    e_vb = !(v_line >= 33 && v_line < 513);
    e_fs = (v_line == 33) && (old_line != 33);
    e_r = widen(p[1:0]);
    e_g = widen(p[3:2]);
    e_b = widen(p[5:4]);
`ifdef GIGATRON_SCANLINE_EN
    if (scanline_on && (v_line % 2 == 1)) begin
      e_r = e_r >> 1; e_g = e_g >> 1; e_b = e_b >> 1;
    end
`endif
    if (e_hb || e_vb) begin
      e_r = 0; e_g = 0; e_b = 0;
    end
    e_hs = !p[6];
    e_vs = !p[7];
  endtask

  task automatic check_model();
    chk("model_R", vid.VGA_R, e_r);
    chk("model_G", vid.VGA_G, e_g);
    chk("model_B", vid.VGA_B, e_b);
    chk("model_HS", vid.VGA_HS, e_hs);
    chk("model_VS", vid.VGA_VS, e_vs);
    chk("model_HBlank", vid.HBlank, e_hb);
    chk("model_VBlank", vid.VBlank, e_vb);
    chk("model_ce_pix", vid.ce_pix, e_cepix);
    chk("model_frame_start", vid.frame_start, e_fs);
    chk("model_h_locked", vid.h_locked, e_lock);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_R"}, vid.VGA_R, 0);
    chk({tag, "_G"}, vid.VGA_G, 0);
    chk({tag, "_B"}, vid.VGA_B, 0);
    chk({tag, "_HS"}, vid.VGA_HS, 0);
    chk({tag, "_VS"}, vid.VGA_VS, 0);
    chk({tag, "_HBlank"}, vid.HBlank, 1);
    chk({tag, "_VBlank"}, vid.VBlank, 1);
    chk({tag, "_ce_pix"}, vid.ce_pix, 0);
    chk({tag, "_frame_start"}, vid.frame_start, 0);
    chk({tag, "_h_locked"}, vid.h_locked, 0);
  endtask

  task automatic step(input bit c, input logic [7:0] p);
    @(negedge clk_sys);
    ce = c;
    out_port = p;
    @(posedge clk_sys);
    model_update(c, p);
    #1;
    check_model();
  endtask

  task automatic run_line(input int len, input int low, input bit vs_n, input int gap_pct,
                          output int fs_n, output bit vb_low);
    fs_n = 0;
    vb_low = 0;
    for (int i = 0; i < len; i++) begin
      while (int'($urandom_range(99)) < gap_pct) step(1'b0, 8'($urandom));
      step(1'b1, {vs_n, (i < len - low), 6'($urandom)});
      if (vid.frame_start) fs_n++;
      if (!vid.VBlank) vb_low = 1;
    end
  endtask

  initial begin
    int         fs_n, fs_total, fs_line, first_vb, last_vb, len, low;
    bit         vbl, vsn;
    logic [7:0] exp_odd;

    tbl[0] = '{1'b1, 8'hE6, 8'hAA, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'hC0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'hD5, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'hEC, 8'h00, 8'hFF, 8'hAA, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'hAA, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'hF9, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'hC3, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 8'hDB, 8'hFF, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1};

    // Reset state
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_reset_values("reset");
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys) reset_n = 1'b1;
    step(1'b0, 8'hFF);

    // 200-cycle lines, hsync_n low for 24
    for (int i = 0; i < 24; i++) step(1'b1, {2'b10, 6'($urandom)});
    for (int n = 1; n <= 4; n++) begin
      for (int i = 0; i < 200; i++) begin
        step(1'b1, {1'b1, (i < 176), 6'($urandom)});
        if (i == 0)   chk("h_locked_at_edge", vid.h_locked, (n >= 3));
        if (i == 11)  chk("hblank_before_12", vid.HBlank, 1);
        if (i == 12)  chk("hblank_at_12", vid.HBlank, 0);
        if (i == 171) chk("hblank_at_171", vid.HBlank, 0);
        if (i == 172) chk("hblank_at_172", vid.HBlank, 1);
      end
    end

    // Walk to active line 33, column 12, then apply the vector table
    run_line(20, 4, 1'b0, 0, fs_n, vbl);
    for (int l = 0; l < 33; l++) run_line(20, 4, 1'b1, 0, fs_n, vbl);
    for (int i = 0; i < 12; i++) step(1'b1, {2'b11, 6'($urandom)});
    foreach (tbl[k]) begin
      step(tbl[k].c, tbl[k].p);
      chk("tbl_R", vid.VGA_R, tbl[k].r);
      chk("tbl_G", vid.VGA_G, tbl[k].g);
      chk("tbl_B", vid.VGA_B, tbl[k].b);
      chk("tbl_HS", vid.VGA_HS, tbl[k].hs);
      chk("tbl_VS", vid.VGA_VS, tbl[k].vs);
      chk("tbl_ce_pix", vid.ce_pix, tbl[k].cp);
    end

`ifdef GIGATRON_SCANLINE_EN
    exp_odd = 8'h7F;
`else
    exp_odd = 8'hFF;
`endif
    scanline_on = 1'b1;
    step(1'b1, 8'hFF);
    chk("scanline_odd_R", vid.VGA_R, exp_odd);
    chk("scanline_odd_B", vid.VGA_B, exp_odd);
    scanline_on = 1'b0;
    step(1'b1, 8'hA6);
    chk("hs_asserted", vid.VGA_HS, 1);
    chk("hs_asserted_R", vid.VGA_R, 8'hAA);
    for (int i = 0; i < 3; i++) step(1'b1, {2'b10, 6'($urandom)});
    for (int i = 0; i < 12; i++) step(1'b1, {2'b11, 6'($urandom)});
    scanline_on = 1'b1;
    step(1'b1, 8'hFF);
    chk("scanline_even_G", vid.VGA_G, 8'hFF);
    scanline_on = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, {2'b10, 6'($urandom)});

    // Two 521-line frames with a 2-line vsync and ce gaps
    for (int l = 0; l < 2; l++) run_line(20, 4, 1'b0, 0, fs_n, vbl);
    for (int f = 0; f < 2; f++) begin
      fs_total = 0; fs_line = -1; first_vb = -1; last_vb = -1;
      for (int l = 0; l < 521; l++) begin
        run_line(20, 4, (l < 519), 20, fs_n, vbl);
        fs_total += fs_n;
        if (fs_n > 0) fs_line = l;
        if (vbl) begin
          if (first_vb < 0) first_vb = l;
          last_vb = l;
        end
      end
      chk("frame_start_count", fs_total, 1);
      chk("frame_start_line", fs_line, 33);
      chk("vblank_first_active", first_vb, 33);
      chk("vblank_last_active", last_vb, 512);
    end

    // Sync stops: period saturates and lock drops
    chk("locked_before_stop", vid.h_locked, 1);
    for (int k = 0; k < 600; k++) begin
      step(1'b1, {2'b11, 6'($urandom)});
      if (k == 510) chk("locked_at_510", vid.h_locked, 1);
      if (k == 511) chk("unlocked_at_511", vid.h_locked, 0);
    end
    chk("stopped_hblank", vid.HBlank, 1);

    // Asynchronous reset mid-line with ce idle
    for (int l = 0; l < 3; l++) run_line(20, 4, 1'b1, 0, fs_n, vbl);
    for (int i = 0; i < 5; i++) step(1'b1, {2'b11, 6'($urandom)});
    @(negedge clk_sys);
    ce = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    @(negedge clk_sys) reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, {2'b10, 6'($urandom)});
    for (int n = 1; n <= 4; n++) begin
      for (int i = 0; i < 30; i++) begin
        step(1'b1, {1'b1, (i < 24), 6'($urandom)});
        if (i == 0) chk("relock_at_edge", vid.h_locked, (n >= 3));
      end
    end

    // Randomised lines, vsyncs, ce gaps and scanline requests
    for (int l = 0; l < 110; l++) begin
      len = ($urandom_range(7) == 0) ? int'($urandom_range(60, 5)) : 40;
      low = int'($urandom_range(len - 1, 1));
      vsn = ($urandom_range(9) != 0);
      scanline_on = 1'($urandom);
      run_line(len, low, vsn, 30, fs_n, vbl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
